demux4x1_buf: RTL and testbench

DEMUX4X1_BUF -- requirements
Module: demux4x1_buf

---
 rtl/demux4x1_buf.sv | 59 +++++
 tb/tb_demux4x1_buf.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/demux4x1_buf.sv
// 1-to-4 nibble demultiplexer with a one-entry valid/ready buffer on every lane.
// Also counts accepted nibbles in a wrapping 8-bit counter.
module demux4x1_buf (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_data,
    input  logic [1:0] s,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] out0,
    output logic [3:0] out1,
    output logic [3:0] out2,
    output logic [3:0] out3,
    output logic [3:0] out_valid,
    input  logic [3:0] out_ready,
    output logic [7:0] acc_count
);

    logic [3:0][3:0] data_q, data_d;
    logic [3:0]      valid_q, valid_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            accept;

    // A full lane can take new data in the same cycle its consumer drains it.
    assign in_ready = ~valid_q[s] | out_ready[s];
    assign accept   = in_valid & in_ready;

    always_comb begin
        data_d  = data_q;
        // Lanes that are valid and ready drain; ready on an empty lane is harmless.
        valid_d = valid_q & ~out_ready;
        cnt_d   = cnt_q;
        if (accept) begin
            data_d[s]  = in_data;
            valid_d[s] = 1'b1;
            cnt_d      = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out0      = data_q[0];
    assign out1      = data_q[1];
    assign out2      = data_q[2];
    assign out3      = data_q[3];
    assign out_valid = valid_q;
    assign acc_count = cnt_q;

endmodule

// File: tb/tb_demux4x1_buf.sv
// Directed self-checking bench for demux4x1_buf; expected values are hand-computed.
module tb_demux4x1_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_data;
    logic [1:0] s;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out0, out1, out2, out3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] acc_count;

    int total = 0;
    int bad   = 0;

    demux4x1_buf dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_count (acc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [3:0] d);
        s        = sel;
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_lanes(input string tag, input logic [15:0] exp);
        check(tag, {16'h0, out3, out2, out1, out0}, {16'h0, exp});
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 4'h0;
        s         = 2'd0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        tick();
        check("rst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        check_lanes("rst_data", 16'h0000);
        check("rst_valid", out_valid, 0);
        check("rst_count", acc_count, 0);

        // Basic routing, first accept right after reset release
        send(2'd0, 4'h9);
        check("route_lat_valid", out_valid, 4'b0001);
        check("route_lat_out0", out0, 4'h9);
        send(2'd1, 4'hA);
        send(2'd2, 4'hB);
        send(2'd3, 4'hC);
        check_lanes("route_data", 16'hCBA9);
        check("route_valid", out_valid, 4'b1111);
        check("route_count", acc_count, 4);

        // Backpressure on lane 2
        out_ready = 4'b0100;
        tick();
        check("bp_drain_valid", out_valid, 4'b1011);
        out_ready = 4'b0000;
        send(2'd2, 4'h5);
        check("bp_fill_out2", out2, 4'h5);
        check("bp_fill_count", acc_count, 5);
        s        = 2'd2;
        in_data  = 4'h7;
        in_valid = 1'b1;
        #1;
        check("bp_in_ready_low", in_ready, 0);
        tick();
        check("bp_hold_out2", out2, 4'h5);
        check("bp_hold_count", acc_count, 5);
        out_ready = 4'b0100;
        #1;
        check("bp_in_ready_high", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        check("bp_out2", out2, 4'h7);
        check("bp_valid", out_valid, 4'b1111);
        check("bp_count", acc_count, 6);

        // Select/data changes with in_valid low do nothing
        s       = 2'd1;
        in_data = 4'h3;
        tick();
        check_lanes("idle_data", 16'hC7A9);
        check("idle_count", acc_count, 6);

        // Parallel drain
        out_ready = 4'b1111;
        tick();
        check("pd_valid", out_valid, 4'b0000);
        check_lanes("pd_data", 16'hC7A9);
        tick();
        check("pd_empty_ready_valid", out_valid, 4'b0000);
        out_ready = 4'b0000;

        // Drain lane 1 while refilling lane 3
        send(2'd1, 4'hD);
        check("dr_fill_valid", out_valid, 4'b0010);
        out_ready = 4'b0010;
        send(2'd3, 4'hE);
        out_ready = 4'b0000;
        check("dr_valid", out_valid, 4'b1000);
        check("dr_out3", out3, 4'hE);
        check("dr_out1", out1, 4'hD);
        check("dr_count", acc_count, 8);

        // Counter wrap: 248 more accepts on a continuously draining lane 0
        out_ready = 4'b1111;
        s         = 2'd0;
        in_data   = 4'h6;
        in_valid  = 1'b1;
        for (int i = 0; i < 248; i++) tick();
        check("wrap_zero", acc_count, 8'h00);
        tick();
        check("wrap_one", acc_count, 8'h01);
        in_valid = 1'b0;
        tick();
        out_ready = 4'b0000;
        check("wrap_drained", out_valid, 4'b0000);

        // Reset mid-operation with a simultaneous drain+accept on lane 0
        send(2'd0, 4'h1);
        send(2'd1, 4'h2);
        send(2'd2, 4'h3);
        send(2'd3, 4'h4);
        check("mid_count", acc_count, 5);
        check("mid_valid", out_valid, 4'b1111);
        rst       = 1'b1;
        s         = 2'd0;
        in_data   = 4'hF;
        in_valid  = 1'b1;
        out_ready = 4'b0001;
        #1;
        check("mid_in_ready", in_ready, 1);
        tick();
        out_ready = 4'b0000;
        check_lanes("mid_rst_data", 16'h0000);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", acc_count, 0);
        check("mid_rst_in_ready", in_ready, 1);
        tick();
        check("mid_rst_no_count", acc_count, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("post_rst_count", acc_count, 0);
        check("post_rst_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
